// File: rtl/debounce_multi_if.sv
// Board-side bundle for debounce_multi: raw switch inputs in, debounced levels and tick pulses out.
interface debounce_multi_if #(
    parameter int unsigned CHANNELS = 4
);
    logic [CHANNELS-1:0] sw;
    logic [CHANNELS-1:0] db_level;
    logic [CHANNELS-1:0] rise_tick;
    logic [CHANNELS-1:0] fall_tick;
    logic [CHANNELS-1:0] rpt_tick;
    logic                any_tick;

    modport master (
        output sw,
        input  db_level, rise_tick, fall_tick, rpt_tick, any_tick
    );

    modport slave (
        input  sw,
        output db_level, rise_tick, fall_tick, rpt_tick, any_tick
    );
endinterface

// File: rtl/debounce_multi.sv
// Multi-channel switch debouncer: per-channel synchroniser, press/release debounce FSM,
// rise/fall tick pulses and optional auto-repeat while held.
module debounce_multi #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned N        = 20,
    parameter int unsigned LIMIT    = 2**20-1,
    parameter int unsigned RW       = 24,
    parameter int unsigned REPEAT   = 0
) (
    input  logic            clk,
    input  logic            reset,
    debounce_multi_if.slave bus
);
    // state[1] doubles as the debounced level
    localparam logic [1:0] ZERO  = 2'b00;
    localparam logic [1:0] WAIT1 = 2'b01;
    localparam logic [1:0] ONE   = 2'b10;
    localparam logic [1:0] WAIT0 = 2'b11;

    localparam logic [N-1:0] LIMIT_N = N'(LIMIT);

    logic [CHANNELS-1:0] s1, s;
    logic [1:0]          state     [CHANNELS];
    logic [1:0]          state_nxt [CHANNELS];
    logic [N-1:0]        cnt       [CHANNELS];
    logic [N-1:0]        cnt_nxt   [CHANNELS];
    logic [CHANNELS-1:0] rise_nxt, fall_nxt, level;
    logic [CHANNELS-1:0] rise_q, fall_q;
    logic                any_q;

    always_comb begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            state_nxt[i] = state[i];
            cnt_nxt[i]   = cnt[i];
            rise_nxt[i]  = 1'b0;
            fall_nxt[i]  = 1'b0;
            level[i]     = state[i][1];
            case (state[i])
                ZERO: if (s[i]) begin
                    state_nxt[i] = WAIT1;
                    cnt_nxt[i]   = LIMIT_N;
                end
                WAIT1: if (!s[i]) begin
                    state_nxt[i] = ZERO;
                end else if (cnt[i] == N'(1)) begin
                    state_nxt[i] = ONE;
                    cnt_nxt[i]   = '0;
                    rise_nxt[i]  = 1'b1;
                end else begin
                    cnt_nxt[i] = cnt[i] - N'(1);
                end
                ONE: if (!s[i]) begin
                    state_nxt[i] = WAIT0;
                    cnt_nxt[i]   = LIMIT_N;
                end
                WAIT0: if (s[i]) begin
                    state_nxt[i] = ONE;
                end else if (cnt[i] == N'(1)) begin
                    state_nxt[i] = ZERO;
                    cnt_nxt[i]   = '0;
                    fall_nxt[i]  = 1'b1;
                end else begin
                    cnt_nxt[i] = cnt[i] - N'(1);
                end
                default: begin
                    state_nxt[i] = ZERO;
                    cnt_nxt[i]   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1     <= '0;
            s      <= '0;
            rise_q <= '0;
            fall_q <= '0;
            any_q  <= 1'b0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                state[i] <= ZERO;
                cnt[i]   <= '0;
            end
        end else begin
            s1     <= bus.sw;
            s      <= s1;
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            rise_q <= rise_nxt;
            fall_q <= fall_nxt;
            any_q  <= |{rise_nxt, fall_nxt};
        end
    end

    generate
        if (REPEAT > 0) begin : g_repeat
            localparam logic [RW-1:0] REPEAT_N = RW'(REPEAT);
            logic [RW-1:0]       rcnt [CHANNELS];
            logic [CHANNELS-1:0] rpt_q;

            // Every entry into ONE (fresh press or aborted release) restarts a full period
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rpt_q <= '0;
                    for (int unsigned i = 0; i < CHANNELS; i++) rcnt[i] <= '0;
                end else begin
                    rpt_q <= '0;
                    for (int unsigned i = 0; i < CHANNELS; i++) begin
                        if (state_nxt[i] == ONE && state[i] != ONE) begin
                            rcnt[i] <= REPEAT_N;
                        end else if (state[i] == ONE && s[i]) begin
                            if (rcnt[i] == RW'(1)) begin
                                rpt_q[i] <= 1'b1;
                                rcnt[i]  <= REPEAT_N;
                            end else begin
                                rcnt[i] <= rcnt[i] - RW'(1);
                            end
                        end
                    end
                end
            end
            assign bus.rpt_tick = rpt_q;
        end else begin : g_no_repeat
            assign bus.rpt_tick = '0;
        end
    endgenerate

    assign bus.db_level  = level;
    assign bus.rise_tick = rise_q;
    assign bus.fall_tick = fall_q;
    assign bus.any_tick  = any_q;
endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi: 2 channels, LIMIT=4, REPEAT=3.
module tb_debounce_multi;
    localparam int unsigned CH  = 2;
    localparam int unsigned LIM = 4;
    localparam int unsigned REP = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    debounce_multi_if #(.CHANNELS(CH)) bus ();

    debounce_multi #(
        .CHANNELS(CH),
        .N       (4),
        .LIMIT   (LIM),
        .RW      (4),
        .REPEAT  (REP)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [1:0] sw;
        logic [1:0] lvl;
        logic [1:0] rise;
        logic [1:0] fall;
        logic [1:0] rpt;
        logic       any;
    } vec_t;

    vec_t tbl [19];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [1:0] lvl, input logic [1:0] rise,
                         input logic [1:0] fall, input logic [1:0] rpt, input logic any);
        logic [8:0] act;
        logic [8:0] exp;
        act = {bus.db_level, bus.rise_tick, bus.fall_tick, bus.rpt_tick, bus.any_tick};
        exp = {lvl, rise, fall, rpt, any};
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: {lvl,rise,fall,rpt,any} got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] sw_v, input string name, input logic [1:0] lvl,
                         input logic [1:0] rise, input logic [1:0] fall, input logic [1:0] rpt,
                         input logic any);
        bus.sw = sw_v;
        step();
        check(name, lvl, rise, fall, rpt, any);
    endtask

    initial begin
        // clean press on ch0 from reset: edges 1..9
        for (int i = 0; i < 6; i++) tbl[i] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
        tbl[6] = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 1'b1};
        tbl[7] = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0};
        tbl[8] = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0};
        // simultaneous press on both channels: edges 1..10
        for (int i = 9; i < 15; i++) tbl[i] = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
        tbl[15] = '{2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 1'b1};
        tbl[16] = '{2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0};
        tbl[17] = '{2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0};
        tbl[18] = '{2'b11, 2'b11, 2'b00, 2'b00, 2'b11, 1'b0};

        reset  = 1'b1;
        bus.sw = 2'b00;
        step(); step(); step();
        check("reset_state", 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < 9; i++)
            drive(tbl[i].sw, "clean_press", tbl[i].lvl, tbl[i].rise, tbl[i].fall, tbl[i].rpt, tbl[i].any);

        // held: rise was at edge 7, repeat every 3rd edge
        for (int e = 10; e <= 19; e++)
            drive(2'b01, "repeat_held", 2'b01, 2'b00, 2'b00,
                  ((e - 7) % 3 == 0) ? 2'b01 : 2'b00, 1'b0);

        // 2-cycle release glitch must not drop the level or tick
        for (int e = 20; e <= 26; e++)
            drive((e < 22) ? 2'b00 : 2'b01, "release_bounce", 2'b01, 2'b00, 2'b00, 2'b00, 1'b0);
        drive(2'b01, "repeat_after_bounce", 2'b01, 2'b00, 2'b00, 2'b01, 1'b0);

        // sustained release applied before edge 28: fall at 28+6
        for (int e = 28; e <= 35; e++)
            drive(2'b00, "release", (e < 34) ? 2'b01 : 2'b00, 2'b00,
                  (e == 34) ? 2'b01 : 2'b00, 2'b00, (e == 34));

        // re-press: rise at 42, first repeat a full period later at 45
        for (int e = 36; e <= 45; e++)
            drive(2'b01, "repress", (e >= 42) ? 2'b01 : 2'b00, (e == 42) ? 2'b01 : 2'b00,
                  2'b00, (e == 45) ? 2'b01 : 2'b00, (e == 42));

        for (int e = 46; e <= 55; e++)
            drive(2'b00, "release2", (e < 52) ? 2'b01 : 2'b00, 2'b00,
                  (e == 52) ? 2'b01 : 2'b00, 2'b00, (e == 52));

        for (int i = 9; i < 19; i++)
            drive(tbl[i].sw, "simultaneous", tbl[i].lvl, tbl[i].rise, tbl[i].fall, tbl[i].rpt, tbl[i].any);

        for (int k = 1; k <= 10; k++)
            drive(2'b00, "release_both", (k < 7) ? 2'b11 : 2'b00, 2'b00,
                  (k == 7) ? 2'b11 : 2'b00, 2'b00, (k == 7));

        // press bounce: last WAIT1 entry at edge 7, rise at 11
        for (int k = 1; k <= 12; k++)
            drive((k == 2 || k == 4) ? 2'b00 : 2'b01, "press_bounce",
                  (k >= 11) ? 2'b01 : 2'b00, (k == 11) ? 2'b01 : 2'b00, 2'b00, 2'b00, (k == 11));

        // repeat counter expires one edge into the release, before WAIT0 is reached
        for (int k = 1; k <= 10; k++)
            drive(2'b00, "release3", (k < 7) ? 2'b01 : 2'b00, 2'b00,
                  (k == 7) ? 2'b01 : 2'b00, (k == 2) ? 2'b01 : 2'b00, (k == 7));

        // reset while ch0 sits in WAIT1 with cnt=2
        for (int k = 1; k <= 5; k++)
            drive(2'b01, "pre_reset", 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        reset = 1'b1;
        #1;
        check("reset_async", 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        step(); step();
        check("reset_held", 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        reset = 1'b0;
        for (int k = 1; k <= 8; k++)
            drive(2'b01, "after_reset", (k >= 7) ? 2'b01 : 2'b00, (k == 7) ? 2'b01 : 2'b00,
                  2'b00, 2'b00, (k == 7));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
